// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq
//  Purpose  : Sequences the two resets of a dual-clock FIFO from a single
//             clock domain. Both FIFO resets are held low together, the read
//             domain is released first, and the write domain follows after a
//             programmable gap. A sequence starts either from a power-on or
//             wrst_n reset (no acknowledge) or from a req/ack handshake.
//
//  Parameters
//    HOLD_CYCLES  cycles both FIFO resets stay low together   (1..255)
//    GAP_CYCLES   cycles between read and write release       (1..255)
//
//  Ports
//    wclk         in   1  clock, all logic on its rising edge
//    wrst_n       in   1  synchronous active-low reset
//    req          in   1  reset request, held high until ack is seen
//    ack          out  1  request sequence complete (registered)
//    busy         out  1  sequencer not idle (registered)
//    fifo_wrst_n  out  1  active-low reset to the FIFO write domain
//    fifo_rrst_n  out  1  active-low reset to the FIFO read domain
//    seq_cnt      out  8  completed request sequences, wraps 255->0
//                         (present only when RST_SEQ_CNT_EN is defined)
//
//  Build option
//    RST_SEQ_CNT_EN  define to add the seq_cnt port and its counter.
//
//  Revision : 1.0  initial release
// ============================================================================
module rst_seq #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       wclk,
  input  logic       wrst_n,
  input  logic       req,
  output logic       ack,
  output logic       busy,
  output logic       fifo_wrst_n,
  output logic       fifo_rrst_n
`ifdef RST_SEQ_CNT_EN
  ,
  output logic [7:0] seq_cnt
`endif
);

  // Terminal counts. The counter starts at 0 on the first cycle of a phase,
  // so the phase ends on the edge where it already shows LAST.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  // High when the running sequence came from wrst_n rather than req; such a
  // sequence returns straight to IDLE and never raises ack.
  logic       por;
  logic       por_nxt;
  logic       rrst_nxt;
  logic       wrst_nxt;

  // --------------------------------------------------------------------------
  // State and output registers. Every output is a flop loaded from the
  // next-state decode, so outputs change on the same edge as the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state       <= HOLD;
      cnt         <= 8'd0;
      por         <= 1'b1;
      fifo_rrst_n <= 1'b0;
      fifo_wrst_n <= 1'b0;
      ack         <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      por         <= por_nxt;
      fifo_rrst_n <= rrst_nxt;
      fifo_wrst_n <= wrst_nxt;
      ack         <= (state_nxt == DONE);
      busy        <= (state_nxt != IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output decode.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    por_nxt   = por;
    rrst_nxt  = fifo_rrst_n;
    wrst_nxt  = fifo_wrst_n;

    case (state)
      IDLE: begin
        rrst_nxt = 1'b1;
        wrst_nxt = 1'b1;
        if (req) begin
          state_nxt = HOLD;
          cnt_nxt   = 8'd0;
          por_nxt   = 1'b0;
          rrst_nxt  = 1'b0;
          wrst_nxt  = 1'b0;
        end
      end

      HOLD: begin
        rrst_nxt = 1'b0;
        wrst_nxt = 1'b0;
        if (cnt == HOLD_LAST) begin
          // Read domain comes out of reset first.
          state_nxt = GAP;
          cnt_nxt   = 8'd0;
          rrst_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      GAP: begin
        rrst_nxt = 1'b1;
        wrst_nxt = 1'b0;
        if (cnt == GAP_LAST) begin
          wrst_nxt  = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = por ? IDLE : DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      DONE: begin
        rrst_nxt = 1'b1;
        wrst_nxt = 1'b1;
        // A req already dropped during the sequence gives a one-cycle ack.
        if (!req) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 8'd0;
        rrst_nxt  = 1'b1;
        wrst_nxt  = 1'b1;
      end
    endcase
  end

`ifdef RST_SEQ_CNT_EN
  // --------------------------------------------------------------------------
  // Completed request sequences, counted on the DONE -> IDLE transition.
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      seq_cnt <= 8'd0;
    end else if ((state == DONE) && (state_nxt == IDLE)) begin
      seq_cnt <= seq_cnt + 8'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The write domain must never be out of reset while the read domain is
  // still held, and ack only ever appears inside a busy window.
  a_read_first : assert property (@(posedge wclk) disable iff (!wrst_n)
                                  fifo_wrst_n |-> fifo_rrst_n);
  a_ack_busy   : assert property (@(posedge wclk) disable iff (!wrst_n)
                                  ack |-> busy);
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_seq
//  Purpose  : Self-checking bench for rst_seq with HOLD_CYCLES=8,
//             GAP_CYCLES=2. Expected outputs come from a window model:
//             for a sequence starting at edge 0, the read reset is low for
//             samples [0,H), the write reset for [0,H+G), and ack covers
//             [H+G, exit) where exit is the first edge after H+G with req low.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_seq;

  localparam int H  = 8;
  localparam int G  = 2;
  localparam int HG = H + G;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  logic req    = 1'b0;
  logic ack;
  logic busy;
  logic fifo_wrst_n;
  logic fifo_rrst_n;
`ifdef RST_SEQ_CNT_EN
  logic [7:0] seq_cnt;
  logic [7:0] exp_cnt = 8'd0;
`endif

  int errors = 0;
  int checks = 0;

  rst_seq #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G)
  ) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .req         (req),
    .ack         (ack),
    .busy        (busy),
    .fifo_wrst_n (fifo_wrst_n),
    .fifo_rrst_n (fifo_rrst_n)
`ifdef RST_SEQ_CNT_EN
    ,
    .seq_cnt     (seq_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  // Reference: {fifo_rrst_n, fifo_wrst_n, ack, busy} at sample k, taken just
  // after edge k of a sequence whose first low cycle is sample 0.
  function automatic logic [3:0] model(input int k, input bit por, input int exit_edge);
    logic rr, ww, ak, bz;
    rr = (k >= H);
    ww = (k >= HG);
    ak = !por && (k >= HG) && (k < exit_edge);
    bz = por ? (k < HG) : (k < exit_edge);
    return {rr, ww, ak, bz};
  endfunction

  function automatic int exit_of(input int r);
    return (r > HG + 1) ? r : HG + 1;
  endfunction

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [3:0] obs, exp;
    wrst_n = 1'b0;
    req    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      checks++;
      if (obs !== 4'b0001) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%b exp=0001", i, obs);
      end
`ifdef RST_SEQ_CNT_EN
      checks++;
      if (seq_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_seq_cnt got=%0d exp=0", seq_cnt);
      end
`endif
    end
`ifdef RST_SEQ_CNT_EN
    exp_cnt = 8'd0;
`endif
    wrst_n = 1'b1;
    for (int k = 1; k <= HG + 2; k++) begin
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      exp = model(k, 1'b1, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL power_on k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // req dropped one cycle after ack rises: ack high for two cycles.
  task automatic test_basic_request();
    logic [3:0] obs, exp;
    int r, e;
    r = HG + 2;
    e = exit_of(r);
    for (int k = 0; k <= e + 1; k++) begin
      req = (k < r);
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      exp = model(k, 1'b0, e);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic_req k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    req = 1'b0;
`ifdef RST_SEQ_CNT_EN
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (seq_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL basic_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
    end
`endif
  endtask

  // --------------------------------------------------------------------------
  // One-cycle req pulse: full sequence, one-cycle ack.
  task automatic test_short_request();
    logic [3:0] obs, exp;
    int e;
    e = exit_of(1);
    for (int k = 0; k <= e + 1; k++) begin
      req = (k < 1);
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      exp = model(k, 1'b0, e);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL short_req k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
`ifdef RST_SEQ_CNT_EN
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (seq_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL short_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
    end
`endif
  endtask

  // --------------------------------------------------------------------------
  // Random req lengths separated by random idle stretches.
  task automatic test_random_requests();
    logic [3:0] obs, exp;
    int r, e, gap;
    for (int n = 0; n < 20; n++) begin
      gap = $urandom_range(0, 3);
      req = 1'b0;
      for (int i = 0; i < gap; i++) begin
        tick();
        obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
        checks++;
        if (obs !== 4'b1100) begin
          errors++;
          $display("FAIL idle n=%0d got=%b exp=1100", n, obs);
        end
      end
      r = $urandom_range(1, HG + 6);
      e = exit_of(r);
      for (int k = 0; k <= e; k++) begin
        req = (k < r);
        tick();
        obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
        exp = model(k, 1'b0, e);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL rand_req n=%0d r=%0d k=%0d got=%b exp=%b", n, r, k, obs, exp);
        end
      end
      req = 1'b0;
`ifdef RST_SEQ_CNT_EN
      exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (seq_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL rand_seq_cnt n=%0d got=%0d exp=%0d", n, seq_cnt, exp_cnt);
      end
`endif
    end
  endtask

  // --------------------------------------------------------------------------
  // req held high across reset: power-on runs without ack, then the request
  // starts the cycle after IDLE is entered.
  task automatic test_req_during_por();
    logic [3:0] obs, exp;
    int r, e;
    wrst_n = 1'b0;
    req    = 1'b1;
    tick();
    tick();
    obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
    checks++;
    if (obs !== 4'b0001) begin
      errors++;
      $display("FAIL por_req_reset got=%b exp=0001", obs);
    end
`ifdef RST_SEQ_CNT_EN
    exp_cnt = 8'd0;
`endif
    wrst_n = 1'b1;
    for (int k = 1; k <= HG; k++) begin
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      exp = model(k, 1'b1, 0);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL por_req_phase1 k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    r = HG + 1 + $urandom_range(0, 3);
    e = exit_of(r);
    for (int k = 0; k <= e + 1; k++) begin
      req = (k < r);
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      exp = model(k, 1'b0, e);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL por_req_phase2 k=%0d got=%b exp=%b", k, obs, exp);
      end
    end
    req = 1'b0;
`ifdef RST_SEQ_CNT_EN
    exp_cnt = exp_cnt + 8'd1;
    checks++;
    if (seq_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL por_req_seq_cnt got=%0d exp=%0d", seq_cnt, exp_cnt);
    end
`endif
  endtask

  // --------------------------------------------------------------------------
  // wrst_n asserted mid-sequence (first at cycle 4 of HOLD, then random
  // points up to DONE): immediate reset state, then a fresh power-on.
  task automatic test_abort();
    logic [3:0] obs, exp;
    int a, r;
    r = HG + 3;
    for (int n = 0; n < 4; n++) begin
      a = (n == 0) ? 4 : int'($urandom_range(1, HG + 2));
      for (int k = 0; k < a; k++) begin
        req = (k < r);
        tick();
        obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
        exp = model(k, 1'b0, exit_of(r));
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL abort_pre n=%0d k=%0d got=%b exp=%b", n, k, obs, exp);
        end
      end
      wrst_n = 1'b0;
      req    = 1'b0;
      tick();
      obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
      checks++;
      if (obs !== 4'b0001) begin
        errors++;
        $display("FAIL abort_reset n=%0d a=%0d got=%b exp=0001", n, a, obs);
      end
`ifdef RST_SEQ_CNT_EN
      exp_cnt = 8'd0;
      checks++;
      if (seq_cnt !== 8'd0) begin
        errors++;
        $display("FAIL abort_seq_cnt got=%0d exp=0", seq_cnt);
      end
`endif
      wrst_n = 1'b1;
      for (int k = 1; k <= HG + 1; k++) begin
        tick();
        obs = {fifo_rrst_n, fifo_wrst_n, ack, busy};
        exp = model(k, 1'b1, 0);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL abort_por n=%0d k=%0d got=%b exp=%b", n, k, obs, exp);
        end
      end
    end
  endtask

`ifdef RST_SEQ_CNT_EN
  // --------------------------------------------------------------------------
  // 256 sequences from a fresh reset bring seq_cnt back to 0.
  task automatic test_cnt_wrap();
    wrst_n = 1'b0;
    req    = 1'b0;
    tick();
    wrst_n = 1'b1;
    for (int k = 1; k <= HG + 1; k++) tick();
    exp_cnt = 8'd0;
    for (int n = 0; n < 256; n++) begin
      for (int k = 0; k <= HG + 1; k++) begin
        req = (k < 1);
        tick();
      end
      exp_cnt = exp_cnt + 8'd1;
      if (n == 254 || n == 255) begin
        checks++;
        if (seq_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL cnt_wrap n=%0d got=%0d exp=%0d", n, seq_cnt, exp_cnt);
        end
      end
    end
    checks++;
    if (seq_cnt !== 8'd0) begin
      errors++;
      $display("FAIL cnt_wrap_final got=%0d exp=0", seq_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_request();
    test_short_request();
    test_random_requests();
    test_req_during_por();
    test_abort();
    test_basic_request();
`ifdef RST_SEQ_CNT_EN
    test_cnt_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
